// File: rtl/moxie_pkg.sv
// Shared sizing for the moxie register-hazard scoreboard: default widths and the
// pend-counter width helper. Optional forwarding is enabled by MOXIE_SCOREBOARD_FORWARD_EN.
package moxie_pkg;
    localparam int NREGS       = 16;
    localparam int IDX_W       = 4;
    localparam int DATA_W      = 32;
    localparam int PIPE_DEPTH  = 2;
    localparam int STALL_CNT_W = 16;

    // Bits needed to count 0..depth in-flight writes to one register.
    function automatic int pend_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/cpu_scoreboard_if.sv
// Decode/writeback/operand bundle between the moxie pipeline and its hazard scoreboard.
// The master side is the pipeline, the slave side is the scoreboard.
interface cpu_scoreboard_if #(
    parameter int IDX_W       = 4,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
);
    logic                   flush_i;
    logic                   issue_valid_i;
    logic                   issue_we_i;
    logic [IDX_W-1:0]       issue_widx_i;
    logic                   rdA_en_i;
    logic [IDX_W-1:0]       rdA_idx_i;
    logic                   rdB_en_i;
    logic [IDX_W-1:0]       rdB_idx_i;
    logic [DATA_W-1:0]      rf_valA_i;
    logic [DATA_W-1:0]      rf_valB_i;
    logic                   wb_we_i;
    logic [IDX_W-1:0]       wb_idx_i;
    logic [DATA_W-1:0]      wb_value_i;
    logic                   stall_o;
    logic [DATA_W-1:0]      valA_o;
    logic [DATA_W-1:0]      valB_o;
    logic [STALL_CNT_W-1:0] stall_count_o;

    modport master (
        output flush_i, issue_valid_i, issue_we_i, issue_widx_i,
               rdA_en_i, rdA_idx_i, rdB_en_i, rdB_idx_i, rf_valA_i, rf_valB_i,
               wb_we_i, wb_idx_i, wb_value_i,
        input  stall_o, valA_o, valB_o, stall_count_o
    );

    modport slave (
        input  flush_i, issue_valid_i, issue_we_i, issue_widx_i,
               rdA_en_i, rdA_idx_i, rdB_en_i, rdB_idx_i, rf_valA_i, rf_valB_i,
               wb_we_i, wb_idx_i, wb_value_i,
        output stall_o, valA_o, valB_o, stall_count_o
    );
endinterface

// File: rtl/cpu_scoreboard_entry.sv
// One register's in-flight write counter: +1 on accepted issue, -1 on writeback,
// unchanged when both coincide, cleared by flush, never exceeds PIPE_DEPTH.
module cpu_scoreboard_entry
    import moxie_pkg::*;
#(
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = pend_w(PIPE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);
    logic dec_eff;

    // A writeback to a register with nothing pending is a no-op.
    assign dec_eff = dec && (cnt != '0);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && !dec_eff) begin
            if (cnt != CNT_W'(PIPE_DEPTH)) cnt <= cnt + CNT_W'(1);
        end else if (dec_eff && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/cpu_scoreboard.sv
// Register-hazard scoreboard for the moxie pipeline: stalls decode on RAW and pend overflow,
// counts stall cycles; MOXIE_SCOREBOARD_FORWARD_EN adds writeback-to-operand forwarding.
module cpu_scoreboard
    import moxie_pkg::*;
#(
    parameter int NREGS_P       = NREGS,
    parameter int IDX_W_P       = IDX_W,
    parameter int DATA_W_P      = DATA_W,
    parameter int PIPE_DEPTH_P  = PIPE_DEPTH,
    parameter int STALL_CNT_W_P = STALL_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    cpu_scoreboard_if.slave  sb
);
    localparam int CNT_W = pend_w(PIPE_DEPTH_P);

    logic [CNT_W-1:0] pend [NREGS_P];
    logic [CNT_W-1:0] pend_a, pend_b, pend_w_idx;
    logic             fwd_a, fwd_b, haz_a, haz_b, ovf, stall, accept;
    logic [STALL_CNT_W_P-1:0] stall_count;

    for (genvar r = 0; r < NREGS_P; r++) begin : g_entry
        cpu_scoreboard_entry #(
            .PIPE_DEPTH (PIPE_DEPTH_P),
            .CNT_W      (CNT_W)
        ) u_entry (
            .clk   (clk_i),
            .rst   (rst_i),
            .flush (sb.flush_i),
            .inc   (accept && (sb.issue_widx_i == IDX_W_P'(r))),
            .dec   (sb.wb_we_i && (sb.wb_idx_i == IDX_W_P'(r))),
            .cnt   (pend[r])
        );
    end

    assign pend_a     = pend[sb.rdA_idx_i];
    assign pend_b     = pend[sb.rdB_idx_i];
    assign pend_w_idx = pend[sb.issue_widx_i];

`ifdef MOXIE_SCOREBOARD_FORWARD_EN
    // The last outstanding write is landing this cycle, so its data can bypass the register file.
    assign fwd_a = sb.rdA_en_i && sb.wb_we_i && (sb.wb_idx_i == sb.rdA_idx_i) && (pend_a == CNT_W'(1));
    assign fwd_b = sb.rdB_en_i && sb.wb_we_i && (sb.wb_idx_i == sb.rdB_idx_i) && (pend_b == CNT_W'(1));
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        haz_a  = 1'b0;
        haz_b  = 1'b0;
        ovf    = 1'b0;
        stall  = 1'b0;
        accept = 1'b0;
        if (sb.issue_valid_i) begin
            haz_a  = sb.rdA_en_i && (pend_a != '0) && !fwd_a;
            haz_b  = sb.rdB_en_i && (pend_b != '0) && !fwd_b;
            ovf    = sb.issue_we_i && (pend_w_idx == CNT_W'(PIPE_DEPTH_P));
            stall  = haz_a || haz_b || ovf;
            accept = sb.issue_we_i && !stall;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W_P'(1);
        end
    end

    assign sb.stall_o       = stall;
    assign sb.valA_o        = fwd_a ? sb.wb_value_i : sb.rf_valA_i;
    assign sb.valB_o        = fwd_b ? sb.wb_value_i : sb.rf_valB_i;
    assign sb.stall_count_o = stall_count;
endmodule

// File: tb/tb_cpu_scoreboard.sv
// Self-checking bench for cpu_scoreboard: directed hazard scenarios plus random traffic,
// all compared every cycle against a per-register pending-write model.
module tb_cpu_scoreboard;
    import moxie_pkg::*;

`ifdef MOXIE_SCOREBOARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CNT_MAX = (1 << STALL_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_scoreboard_if sb ();

    cpu_scoreboard dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (sb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model_pend [NREGS];
    int exp_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit valid, input bit we, input int widx,
                         input bit ra_en, input int ra, input bit rb_en, input int rb,
                         input bit wbwe, input int wbi, input logic [31:0] wbv, input bit flush);
        sb.issue_valid_i = valid;
        sb.issue_we_i    = we;
        sb.issue_widx_i  = IDX_W'(widx);
        sb.rdA_en_i      = ra_en;
        sb.rdA_idx_i     = IDX_W'(ra);
        sb.rdB_en_i      = rb_en;
        sb.rdB_idx_i     = IDX_W'(rb);
        sb.wb_we_i       = wbwe;
        sb.wb_idx_i      = IDX_W'(wbi);
        sb.wb_value_i    = wbv;
        sb.flush_i       = flush;
        sb.rf_valA_i     = $urandom;
        sb.rf_valB_i     = $urandom;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    // Expected outputs from the current model state and the inputs now applied.
    task automatic eval_model(output bit es, output logic [31:0] ea, output logic [31:0] eb);
        bit fa, fb, ha, hb, ovf;
        fa  = FWD && sb.rdA_en_i && sb.wb_we_i && (sb.wb_idx_i == sb.rdA_idx_i)
              && (model_pend[sb.rdA_idx_i] == 1);
        fb  = FWD && sb.rdB_en_i && sb.wb_we_i && (sb.wb_idx_i == sb.rdB_idx_i)
              && (model_pend[sb.rdB_idx_i] == 1);
        ha  = sb.rdA_en_i && (model_pend[sb.rdA_idx_i] != 0) && !fa;
        hb  = sb.rdB_en_i && (model_pend[sb.rdB_idx_i] != 0) && !fb;
        ovf = sb.issue_we_i && (model_pend[sb.issue_widx_i] == PIPE_DEPTH);
        es  = sb.issue_valid_i && (ha || hb || ovf);
        ea  = fa ? sb.wb_value_i : sb.rf_valA_i;
        eb  = fb ? sb.wb_value_i : sb.rf_valB_i;
    endtask

    task automatic model_reset();
        foreach (model_pend[r]) model_pend[r] = 0;
        exp_cnt = 0;
    endtask

    // Inputs are applied just after a falling edge; compare, clock once, advance the model.
    task automatic cycle(input int pin_stall = -1);
        bit es;
        logic [31:0] ea, eb;
        #2;
        eval_model(es, ea, eb);
        check("stall", {31'b0, sb.stall_o}, {31'b0, es});
        check("valA", sb.valA_o, ea);
        check("valB", sb.valB_o, eb);
        check("stall_count", 32'(sb.stall_count_o), 32'(exp_cnt));
        if (pin_stall >= 0) check("pinned_stall", {31'b0, sb.stall_o}, 32'(pin_stall));
        @(posedge clk);
        if (sb.flush_i) begin
            foreach (model_pend[r]) model_pend[r] = 0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                bit inc, dec;
                inc = sb.issue_valid_i && sb.issue_we_i && !es && (sb.issue_widx_i == r);
                dec = sb.wb_we_i && (sb.wb_idx_i == r) && (model_pend[r] != 0);
                model_pend[r] = model_pend[r] + int'(inc) - int'(dec);
            end
        end
        if (es && exp_cnt < CNT_MAX) exp_cnt++;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        model_reset();
        idle();
        #1;
        check("reset_stall", {31'b0, sb.stall_o}, 32'h0);
        check("reset_count", 32'(sb.stall_count_o), 32'h0);
        check("reset_valA", sb.valA_o, sb.rf_valA_i);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Mid-run async reset with pend[3]=2 and a nonzero stall count.
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 32'h0, 0); cycle(1);
        drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 32'h0, 0);
        #2;
        check("pre_reset_stall", {31'b0, sb.stall_o}, 32'h1);
        rst = 1'b1;
        #1;
        check("async_reset_stall", {31'b0, sb.stall_o}, 32'h0);
        check("async_reset_count", 32'(sb.stall_count_o), 32'h0);
        check("async_reset_valA", sb.valA_o, sb.rf_valA_i);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0, 1, 3, 1, 3, 0, 0, 32'h0, 0); cycle(0);

        // RAW on r5 until writeback.
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        c0 = exp_cnt;
        repeat (3) begin
            drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 32'h0, 0); cycle(1);
        end
        drive(1, 0, 0, 1, 5, 0, 0, 1, 5, 32'h1111_2222, 0); cycle(FWD ? 0 : 1);
        idle();
        #2;
        check("raw_count", 32'(sb.stall_count_o), 32'(c0 + 3 + (FWD ? 0 : 1)));
        cycle(0);
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 32'h0, 0); cycle(0);

        // Writeback-cycle forwarding on r5.
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        drive(1, 0, 0, 1, 5, 0, 0, 1, 5, 32'hDEAD_BEEF, 0);
        sb.rf_valA_i = 32'h1234_5678;
        #2;
        check("fwd_stall", {31'b0, sb.stall_o}, FWD ? 32'h0 : 32'h1);
        check("fwd_valA", sb.valA_o, FWD ? 32'hDEAD_BEEF : 32'h1234_5678);
        cycle();

        // Overflow on r2 at PIPE_DEPTH in-flight writes.
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(1);
        drive(1, 1, 2, 0, 0, 0, 0, 1, 2, 32'h0, 0); cycle(1);
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        repeat (2) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h0, 0); cycle(0);
        end

        // Simultaneous issue and writeback on r7 keeps pend at 1; flush clears it.
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        drive(1, 1, 7, 0, 0, 0, 0, 1, 7, 32'h0, 0); cycle(0);
        drive(1, 0, 0, 1, 7, 0, 0, 0, 0, 32'h0, 0); cycle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1); cycle(0);
        drive(1, 0, 0, 1, 7, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1); cycle(0);

        // Random traffic concentrated on a few registers to provoke hazards.
        repeat (3000) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 5),
                  $urandom_range(0, 1), $urandom_range(0, 5),
                  $urandom_range(0, 1), $urandom_range(0, 5),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 5), $urandom,
                  $urandom_range(0, 40) == 0);
            cycle();
        end

        // Stall-counter saturation.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1); cycle(0);
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 32'h0, 0); cycle(0);
        repeat (CNT_MAX + 1 + 5) begin
            drive(1, 0, 0, 1, 9, 0, 0, 0, 0, 32'h0, 0); cycle(1);
        end
        idle();
        #2;
        check("sat_count", 32'(sb.stall_count_o), 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
